// File: rtl/uart_tx.sv
// ============================================================================
//  Module   : uart_tx
//  Purpose  : FIFO-buffered 8E1 UART transmitter (start, 8 data LSB first,
//             even parity, stop) with a drift-free integer baud divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               uart_o,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int c_cntr_lim = CLK_FREQ / BAUD_RATE;
  localparam int c_cnt_w    = (c_cntr_lim > 1) ? $clog2(c_cntr_lim) : 1;
  localparam int c_ptr_w    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_count_w  = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(c_cntr_lim - 1);
  localparam logic [c_count_w-1:0] c_full     = c_count_w'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 uart_q, uart_d;
  logic                 busy_q, busy_d;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_count_w-1:0] count_q;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic                 w_tick;
  logic [7:0]           w_head;

  assign tx_ready   = rst_n && (count_q != c_full);
  assign w_push     = tx_valid && tx_ready;
  assign w_nonempty = (count_q != '0);
  assign w_tick     = (cnt_q == c_cnt_last);
  assign w_head     = mem_q[rd_ptr_q];

  assign fifo_count = count_q;
  assign uart_o     = uart_q;
  assign tx_busy    = busy_q;

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      uart_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      uart_q    <= uart_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = w_tick ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    w_pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_nonempty) begin
          w_pop    = 1'b1;
          shift_d  = w_head;
          parity_d = ^w_head;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_nonempty) begin
            w_pop    = 1'b1;
            shift_d  = w_head;
            parity_d = ^w_head;
            state_d  = S_START;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the next state so uart_o is a plain register.
    unique case (state_d)
      S_START:  uart_d = 1'b0;
      S_DATA:   uart_d = shift_d[0];
      S_PARITY: uart_d = parity_d;
      default:  uart_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx; line samples are logged every
//             cycle and compared with frames built from the byte values.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int c_n     = 40000;
  localparam int c_lim_a = 16;
  localparam int c_lim_b = 868;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_uart, b_uart;
  logic       a_busy, b_busy;
  logic [2:0] a_count, b_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit log_a [c_n];
  bit bsy_a [c_n];
  bit log_b [c_n];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .uart_o(a_uart), .tx_busy(a_busy), .fifo_count(a_count)
  );

  uart_tx dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .uart_o(b_uart), .tx_busy(b_busy), .fifo_count(b_count)
  );

  task automatic tick();
    @(negedge clk);
    if (cyc < c_n) begin
      log_a[cyc] = a_uart;
      bsy_a[cyc] = a_busy;
      log_b[cyc] = b_uart;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i of an 8E1 frame for byte b.
  function automatic bit frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic check_frame(input string tag, input bit on_b, input int t0,
                             input int lim, input logic [7:0] b);
    int bad = 0;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < lim; j++) begin
        int idx = t0 + i * lim + j;
        if (idx >= c_n || idx >= cyc) bad++;
        else if ((on_b ? log_b[idx] : log_a[idx]) !== frame_bit(b, i)) bad++;
      end
    end
    check(tag, bad, 0);
  endtask

  task automatic push_a(input logic [7:0] b, output int t0);
    a_data  = b;
    a_valid = 1'b1;
    t0      = cyc + 1;
    tick();
    a_valid = 1'b0;
  endtask

  initial begin
    int t, t0, nb, idx, stall, bad;
    bit r;
    logic [7:0] rb [3];

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    run(2);
    check("rst_uart", a_uart, 1);
    check("rst_busy", a_busy, 0);
    check("rst_count", a_count, 0);
    check("rst_ready", a_ready, 0);
    check("rst_uart_b", b_uart, 1);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", a_ready, 1);

    // Single byte 0xA5 with latency and busy duration
    push_a(8'hA5, t0);
    check("a5_count_after_push", a_count, 1);
    check("a5_uart_before_pop", a_uart, 1);
    tick();
    check("a5_start_uart", a_uart, 0);
    check("a5_start_busy", a_busy, 1);
    check("a5_start_count", a_count, 0);
    run(200);
    check_frame("a5_frame", 1'b0, t0, c_lim_a, 8'hA5);
    nb = 0;
    for (int k = t0 - 1; k < t0 + 200; k++) nb += int'(bsy_a[k]);
    check("a5_busy_len", nb, 176);
    check("a5_busy_last", bsy_a[t0 + 175], 1);
    check("a5_busy_end", bsy_a[t0 + 176], 0);

    // Odd-weight data exercises the parity bit
    push_a(8'h07, t0);
    run(185);
    check_frame("x07_frame", 1'b0, t0, c_lim_a, 8'h07);

    // Random bytes back-to-back
    for (int k = 0; k < 3; k++) rb[k] = 8'($urandom);
    a_valid = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      a_data = rb[k];
      tick();
    end
    a_valid = 1'b0;
    run(3 * 176 + 10);
    for (int k = 0; k < 3; k++) check_frame("rand_frame", 1'b0, t0 + 176 * k, c_lim_a, rb[k]);

    // Backpressure: six bytes with tx_valid held high
    idx = 0; stall = 0;
    a_valid = 1'b1; a_data = 8'h10;
    t = cyc;
    for (int g = 0; g < 600 && idx < 6; g++) begin
      r = a_ready;
      tick();
      if (r) begin
        idx++;
        if (idx == 5) begin
          check("bp_full_count", a_count, 4);
          check("bp_full_ready", a_ready, 0);
        end
        if (idx == 6) check("bp_sixth_push_cycle", cyc - 1, t + 178);
      end else begin
        stall++;
      end
      a_data = 8'h10 + 8'(idx);
    end
    a_valid = 1'b0;
    check("bp_pushed", idx, 6);
    check("bp_stall_len", stall, 173);
    run(6 * 176);
    for (int k = 0; k < 6; k++) check_frame("bp_frame", 1'b0, t + 1 + 176 * k, c_lim_a, 8'h10 + 8'(k));
    check("bp_idle_uart", a_uart, 1);
    check("bp_idle_busy", a_busy, 0);

    // Reset in the middle of data bit 3 of the first of two frames
    a_valid = 1'b1; a_data = 8'h55; t0 = cyc + 1;
    tick();
    a_data = 8'hAA;
    tick();
    a_valid = 1'b0;
    while (cyc < t0 + 4 * c_lim_a + 5) tick();
    check("mid_frame_running", a_busy, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_uart", a_uart, 1);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_ready", a_ready, 0);
    rst_n = 1'b1;
    t = cyc;
    run(400);
    bad = 0;
    for (int k = t; k < cyc; k++) if (log_a[k] !== 1'b1 || bsy_a[k] !== 1'b0) bad++;
    check("post_rst_quiet", bad, 0);

    // Idle hold
    bad = 0;
    repeat (1000) begin
      tick();
      if (a_uart !== 1'b1 || a_ready !== 1'b1) bad++;
    end
    check("idle_hold", bad, 0);

    // Default-parameter instance: 868 clocks per bit
    b_valid = 1'b1; t0 = cyc + 1;
    b_data = 8'h3C; tick();
    b_data = 8'hFF; tick();
    b_data = 8'h00; tick();
    b_valid = 1'b0;
    run(3 * 11 * c_lim_b + 10);
    check_frame("lb_3c", 1'b1, t0, c_lim_b, 8'h3C);
    check_frame("lb_ff", 1'b1, t0 + 11 * c_lim_b, c_lim_b, 8'hFF);
    check_frame("lb_00", 1'b1, t0 + 22 * c_lim_b, c_lim_b, 8'h00);
    check("lb_idle_busy", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that sits directly upstream of the UART receiver. It accepts bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is sent as an 11-bit frame on `uart_o`: start bit, 8 data bits LSB first, even parity bit, one stop bit. This is the frame format the receiver expects. Bit timing is derived from the system clock with the same integer divider the receiver uses, so TX and RX built with equal parameters interoperate.

## Interface
- `CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s. One bit period is `CNTR_LIM = CLK_FREQ/BAUD_RATE` clocks (integer division, truncated); 868 at the defaults.
- `FIFO_DEPTH`, default 4: input buffer entries; must be a power of 2 and at least 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte.
- `uart_o`  out  1  serial line; idles high.
- `tx_busy`  out  1  a frame is on the line (START through STOP).
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of bytes buffered and not yet started.

## Operation
- Push: a byte is written when `tx_valid && tx_ready` is true at a rising edge. `tx_data` is ignored otherwise.
- `tx_ready` = `rst_n && (fifo_count != FIFO_DEPTH)`.
  - When the FIFO is full, no push occurs in that cycle, even if a pop happens on the same edge.
- Simultaneous push and pop leave `fifo_count` unchanged. Data order is strictly FIFO.
- FSM states and transitions:
  - IDLE: `uart_o`=1. When the FIFO is non-empty, pop the head into the shift register, compute parity = XOR of the 8 bits, clear the baud counter, and go to START.
  - START: `uart_o`=0 for `CNTR_LIM` cycles, then go to DATA with bit index 0.
  - DATA: `uart_o` = `shift[0]` for `CNTR_LIM` cycles, then shift right and increment the index. After index 7 completes, go to PARITY.
  - PARITY: `uart_o` = parity bit (even parity: total ones in data+parity is even), for `CNTR_LIM` cycles, then go to STOP.
  - STOP: `uart_o`=1 for `CNTR_LIM` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter:
  - Counts 0..`CNTR_LIM`-1 and wraps to 0 at the bit boundary, where the FSM advances.
  - Free of drift: every bit is exactly `CNTR_LIM` clocks.
- `uart_o`, `tx_busy` and the state are registered; there are no combinational paths from `tx_data` to `uart_o`.
- `tx_busy` is 1 in START, DATA, PARITY and STOP; 0 in IDLE.

## Timing
- Reset (`rst_n`=0 at an edge):
  - Values after that edge: state=IDLE, `uart_o`=1, `tx_busy`=0, `fifo_count`=0, FIFO pointers=0, baud counter=0, shift register=0.
  - `tx_ready`=0 while `rst_n`=0.
- Reset mid-frame aborts the frame: `uart_o` returns to 1 after the reset edge and all buffered bytes are discarded.
- Latency from an IDLE start:
  - Push at edge N into an empty FIFO gives `fifo_count`=1 after N.
  - The pop happens at edge N+1: `uart_o`=0, `tx_busy`=1 and `fifo_count`=0 after N+1.
- Frame length is `11*CNTR_LIM` clocks from the start-bit edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- Pop and push on the same edge are both honoured (subject to the full rule above).
- `fifo_count` never exceeds `FIFO_DEPTH`; the pointers wrap modulo `FIFO_DEPTH`.

## Test plan
- Single byte, `CLK_FREQ`=16, `BAUD_RATE`=1 (16 clk/bit): push 0xA5 -> `uart_o` = 0,1,0,1,0,0,1,0,1,0,1, each level held exactly 16 clocks. The start bit falls 1 clock after the push edge, and `tx_busy` stays high for 176 clocks.
- Odd parity data: push 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop bit 1.
- Backpressure, `FIFO_DEPTH`=4: push 6 bytes 0x10..0x15 on consecutive cycles with `tx_valid` held high.
  - Required: the first pop frees a slot, `tx_ready` falls when `fifo_count`=4, and the stall holds until the next pop.
  - Required: all 6 bytes are sent in order with no idle gap between frames.
- Loopback: connect `uart_o` to a receiver with the default parameters and send 0x3C, 0xFF, 0x00 -> the receiver reports each byte with `rx_done`. The check verifies exactly 868 clk/bit.
- Reset mid-frame: push 0x55 and 0xAA, then assert `rst_n`=0 during bit 3 of the first frame.
  - Required: `uart_o`=1, `fifo_count`=0 and `tx_busy`=0 after the reset edge.
  - Required: no further frame after reset release until a new push.
- Idle hold: no pushes for 1000 cycles after reset -> `uart_o` stays 1 and `tx_ready` stays 1.
